// File: rtl/pipe_control.sv
// Hazard controller for the 5-stage Y86-64 pipeline: stall/bubble generation,
// exception shutdown sequencing (RUN -> DRAIN -> STOPPED) and saturating perf counters.
module pipe_control #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic             halted,
  output logic [3:0]       proc_stat,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;
  localparam logic [3:0] S_AOK    = 4'b1000;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    DRAIN   = 2'b01,
    STOPPED = 2'b10
  } state_e;

  state_e           state_q;
  logic [3:0]       procStat_q;
  logic [CNT_W-1:0] cycleCnt_q, stallCnt_q, bubbleCnt_q, mispredCnt_q;
  logic [CNT_W-1:0] cycleCnt_d, stallCnt_d, bubbleCnt_d, mispredCnt_d;

  logic loadUse, retHaz, misPred, excM, excW, countEn;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic en);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (en && (v != {CNT_W{1'b1}})) ? v + one : v;
  endfunction

  always_comb begin
    excM    = (m_stat != S_AOK);
    excW    = (W_stat != S_AOK);
    loadUse = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != R_NONE) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    retHaz  = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    misPred = (E_icode == I_JXX) && !e_Cnd;
  end

  // Once stopped the whole pipe is frozen; otherwise load/use takes precedence over ret.
  always_comb begin
    F_stall  = 1'b1;
    D_stall  = 1'b1;
    D_bubble = 1'b0;
    E_bubble = 1'b1;
    M_bubble = 1'b1;
    W_stall  = 1'b1;
    set_cc   = 1'b0;
    if (state_q != STOPPED) begin
      F_stall  = loadUse | retHaz;
      D_stall  = loadUse;
      D_bubble = misPred | (retHaz & ~loadUse);
      E_bubble = misPred | loadUse;
      M_bubble = excM | excW;
      W_stall  = excW;
      set_cc   = (E_icode == I_OPQ) & ~excM & ~excW;
    end
  end

  always_comb begin
    countEn      = (state_q != STOPPED);
    cycleCnt_d   = satInc(cycleCnt_q, countEn);
    stallCnt_d   = satInc(stallCnt_q, countEn & D_stall);
    bubbleCnt_d  = satInc(bubbleCnt_q, countEn & (D_bubble | E_bubble));
    mispredCnt_d = satInc(mispredCnt_q, countEn & misPred);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      procStat_q <= S_AOK;
    end else begin
      case (state_q)
        RUN: begin
          if (excW) begin
            state_q    <= STOPPED;
            procStat_q <= W_stat;
          end else if (excM) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (excW) begin
            state_q    <= STOPPED;
            procStat_q <= W_stat;
          end
        end
        STOPPED: state_q <= STOPPED;
        default: state_q <= RUN;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycleCnt_q   <= '0;
      stallCnt_q   <= '0;
      bubbleCnt_q  <= '0;
      mispredCnt_q <= '0;
    end else begin
      cycleCnt_q   <= cycleCnt_d;
      stallCnt_q   <= stallCnt_d;
      bubbleCnt_q  <= bubbleCnt_d;
      mispredCnt_q <= mispredCnt_d;
    end
  end

  assign halted      = (state_q == STOPPED);
  assign proc_stat   = procStat_q;
  assign cycle_cnt   = cycleCnt_q;
  assign stall_cnt   = stallCnt_q;
  assign bubble_cnt  = bubbleCnt_q;
  assign mispred_cnt = mispredCnt_q;

endmodule

// File: tb/tb_pipe_control.sv
// Self-checking bench for pipe_control: a default-width instance plus a 4-bit
// counter instance driven in parallel to exercise counter saturation.
module tb_pipe_control;

  localparam logic [3:0] AOK = 4'b1000;
  localparam logic [3:0] HLT = 4'b0100;
  localparam logic [3:0] ADR = 4'b0010;
  localparam logic [3:0] NOP = 4'h1;
  localparam logic [3:0] RNO = 4'hF;

  logic        clock, reset;
  logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_stat;
  logic        e_Cnd;
  logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
  logic [3:0]  proc_stat;
  logic [31:0] cycle_cnt, stall_cnt, bubble_cnt, mispred_cnt;

  logic        sF_stall, sD_stall, sD_bubble, sE_bubble, sM_bubble, sW_stall, sSet_cc, sHalted;
  logic [3:0]  sProc_stat, sCycle_cnt, sStall_cnt, sBubble_cnt, sMispred_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0]  ctrl;
    logic        halted;
    logic [3:0]  procStat;
    logic [31:0] cyc, stall, bubble, mispred;
    logic [3:0]  stall4;
  } exp_t;

  exp_t sbQ[$];

  // Reference model state
  int          mState;
  logic [3:0]  mProc;
  logic [31:0] mCyc, mStall, mBubble, mMispred;
  logic [3:0]  mStall4;

  pipe_control dut (
    .clock(clock), .reset(reset), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat), .F_stall(F_stall), .D_stall(D_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .set_cc(set_cc), .halted(halted), .proc_stat(proc_stat), .cycle_cnt(cycle_cnt),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .mispred_cnt(mispred_cnt)
  );

  pipe_control #(.CNT_W(4)) dutSmall (
    .clock(clock), .reset(reset), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat), .F_stall(sF_stall), .D_stall(sD_stall),
    .D_bubble(sD_bubble), .E_bubble(sE_bubble), .M_bubble(sM_bubble), .W_stall(sW_stall),
    .set_cc(sSet_cc), .halted(sHalted), .proc_stat(sProc_stat), .cycle_cnt(sCycle_cnt),
    .stall_cnt(sStall_cnt), .bubble_cnt(sBubble_cnt), .mispred_cnt(sMispred_cnt)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] inc32(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  // Called at a negedge; asserts reset off-edge and checks the async clear.
  task automatic applyReset();
    #2 reset = 1'b1;
    #1;
    checkOutput("rstHalted", {31'd0, halted}, 32'd0);
    checkOutput("rstProc", {28'd0, proc_stat}, {28'd0, AOK});
    checkOutput("rstCycle", cycle_cnt, 32'd0);
    checkOutput("rstStall", stall_cnt, 32'd0);
    checkOutput("rstBubble", bubble_cnt, 32'd0);
    checkOutput("rstMispred", mispred_cnt, 32'd0);
    checkOutput("rstStall4", {28'd0, sStall_cnt}, 32'd0);
    mState = 0; mProc = AOK; mCyc = 0; mStall = 0; mBubble = 0; mMispred = 0; mStall4 = 0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Called at a negedge; drives one cycle of inputs, checks, then advances to the next negedge.
  task automatic applyStimulus(input logic [3:0] dI, input logic [3:0] sA, input logic [3:0] sB,
                               input logic [3:0] eI, input logic [3:0] eDst, input logic cnd,
                               input logic [3:0] mI, input logic [3:0] mS, input logic [3:0] wS);
    exp_t e, got;
    logic lu, rt, mp, exM, exW, fs, ds, db, eb, mb, ws, cc;
    D_icode = dI; d_srcA = sA; d_srcB = sB; E_icode = eI; E_dstM = eDst;
    e_Cnd = cnd; M_icode = mI; m_stat = mS; W_stat = wS;

    exM = (mS != AOK);
    exW = (wS != AOK);
    lu  = (eI == 4'h5 || eI == 4'hB) && eDst != RNO && (eDst == sA || eDst == sB);
    rt  = (dI == 4'h9) || (eI == 4'h9) || (mI == 4'h9);
    mp  = (eI == 4'h7) && !cnd;
    if (mState == 2) begin
      fs = 1; ds = 1; db = 0; eb = 1; mb = 1; ws = 1; cc = 0;
    end else begin
      fs = lu | rt; ds = lu; db = mp | (rt & ~lu); eb = mp | lu;
      mb = exM | exW; ws = exW; cc = (eI == 4'h6) & ~exM & ~exW;
    end
    e.ctrl = {fs, ds, db, eb, mb, ws, cc};
    e.halted = (mState == 2);
    e.procStat = mProc;
    e.cyc = mCyc; e.stall = mStall; e.bubble = mBubble; e.mispred = mMispred;
    e.stall4 = mStall4;
    sbQ.push_back(e);

    #1;
    if (sbQ.size() == 0) begin
      checkOutput("sbUnderflow", 32'd1, 32'd0);
    end else begin
      got = sbQ.pop_front();
      checkOutput("ctrl", {25'd0, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc},
                  {25'd0, got.ctrl});
      checkOutput("halted", {31'd0, halted}, {31'd0, got.halted});
      checkOutput("procStat", {28'd0, proc_stat}, {28'd0, got.procStat});
      checkOutput("cycleCnt", cycle_cnt, got.cyc);
      checkOutput("stallCnt", stall_cnt, got.stall);
      checkOutput("bubbleCnt", bubble_cnt, got.bubble);
      checkOutput("mispredCnt", mispred_cnt, got.mispred);
      checkOutput("stallCnt4", {28'd0, sStall_cnt}, {28'd0, got.stall4});
    end

    if (mState != 2) begin
      mCyc     = inc32(mCyc, 1'b1);
      mStall   = inc32(mStall, ds);
      mBubble  = inc32(mBubble, db | eb);
      mMispred = inc32(mMispred, mp);
      if (ds && mStall4 != 4'hF) mStall4 = mStall4 + 4'd1;
      if (exW) begin
        mState = 2;
        mProc  = wS;
      end else if (exM) begin
        mState = 1;
      end
    end
    @(negedge clock);
  endtask

  task automatic nop();
    applyStimulus(NOP, RNO, RNO, NOP, RNO, 1'b1, NOP, AOK, AOK);
  endtask

  initial begin
    reset = 1'b1;
    D_icode = NOP; d_srcA = RNO; d_srcB = RNO; E_icode = NOP; E_dstM = RNO;
    e_Cnd = 1'b1; M_icode = NOP; m_stat = AOK; W_stat = AOK;
    @(negedge clock);
    applyReset();

    nop();
    nop();
    applyStimulus(NOP, 4'h3, RNO, 4'h5, 4'h3, 1'b1, NOP, AOK, AOK);
    applyStimulus(NOP, RNO, RNO, NOP, RNO, 1'b1, 4'h9, AOK, AOK);
    applyStimulus(4'h9, RNO, RNO, 4'h7, RNO, 1'b0, NOP, AOK, AOK);
    applyStimulus(4'h9, RNO, 4'h2, 4'hB, 4'h2, 1'b1, NOP, AOK, AOK);
    applyStimulus(NOP, 4'hF, RNO, 4'h5, RNO, 1'b1, NOP, AOK, AOK);
    applyStimulus(NOP, RNO, RNO, 4'h6, RNO, 1'b1, NOP, AOK, AOK);
    applyStimulus(NOP, RNO, RNO, 4'h7, RNO, 1'b1, NOP, AOK, AOK);

    for (int i = 0; i < 30; i++) begin
      applyStimulus(4'($urandom_range(0, 11)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 11)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 11)), AOK, AOK);
    end

    for (int i = 0; i < 20; i++) begin
      applyStimulus(NOP, 4'h3, RNO, 4'h5, 4'h3, 1'b1, NOP, AOK, AOK);
    end

    applyStimulus(NOP, RNO, RNO, 4'h6, RNO, 1'b1, NOP, ADR, AOK);
    applyStimulus(NOP, RNO, RNO, 4'h6, RNO, 1'b1, NOP, AOK, AOK);
    applyStimulus(NOP, RNO, RNO, NOP, RNO, 1'b1, NOP, AOK, ADR);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'($urandom_range(0, 11)), 4'h3, RNO, 4'h5, 4'h3, 1'b0,
                    4'h9, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    applyReset();
    nop();
    applyStimulus(NOP, RNO, RNO, 4'h6, RNO, 1'b1, NOP, ADR, HLT);
    nop();
    nop();
    applyReset();
    nop();

    checkOutput("sbEmpty", sbQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
